// File: rtl/latency_mem_responder_pkg.sv
// Shared types and constants for the latency memory responder.
// Contents: bus widths, latency counter width, FSM state encoding and the
// packed request payload captured when a request is accepted.
package latency_mem_responder_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/latency_mem_responder_if.sv
// Request/response bus between an initiator (CPU port) and the memory responder.
// Signals: req/wen/addr/wdata from the initiator; ready/rdata/err/busy back.
// master = initiator side, slave = responder side.
interface latency_mem_responder_if;
    import latency_mem_responder_pkg::*;

    logic              req;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, wen, addr, wdata,
        input  ready, rdata, err, busy
    );

    modport slave (
        input  req, wen, addr, wdata,
        output ready, rdata, err, busy
    );

endinterface

// File: rtl/latency_mem_responder_addr_decode.sv
// Combinational byte-address to word-index decode for the responder store.
// Ports: addr_i  byte address
//        idx_o   word index (meaningful only when hit_o=1)
//        hit_o   address inside [BASE_ADDR, BASE_ADDR+4*WORD_DEPTH) and word aligned
module mem_addr_decode
    import latency_mem_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned       WORD_DEPTH = 36,
    parameter int unsigned       IDX_W      = 6
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              hit_o
);

    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(WORD_BYTES * WORD_DEPTH);

    logic [ADDR_W-1:0] off_c;

    // Offset wraps for addresses below base; the >= test rejects those.
    assign off_c = addr_i - BASE_ADDR;
    assign idx_o = IDX_W'(off_c >> 2);
    assign hit_o = (addr_i >= BASE_ADDR) && (off_c < SPAN) && (addr_i[1:0] == 2'b00);

endmodule

// File: rtl/latency_mem_responder.sv
// Word-addressed memory responder with a programmable access latency.
// Ports: clk     rising-edge clock
//        rst     asynchronous active-high reset
//        bus_if  slave side of the req/ready bus (req, wen, addr, wdata in;
//                ready, rdata, err, busy out, all outputs registered)
// The store `mem` is not reset so a bench can preload its contents.
module latency_mem_responder
    import latency_mem_responder_pkg::*;
#(
    parameter int unsigned       WORD_DEPTH = 36,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned       LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    latency_mem_responder_if.slave  bus_if
);

    localparam int unsigned IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    mem_req_t          cap_q,   cap_d;
    logic              ready_q, ready_d;
    logic              err_q,   err_d;
    logic              busy_q,  busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_we_c;
    logic [IDX_W-1:0]  idx_c;
    logic              hit_c;

    logic [DATA_W-1:0] mem [WORD_DEPTH];

    // Decode works on the captured address, never the live bus.
    mem_addr_decode #(
        .BASE_ADDR  (BASE_ADDR),
        .WORD_DEPTH (WORD_DEPTH),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_i (cap_q.addr),
        .idx_o  (idx_c),
        .hit_o  (hit_c)
    );

    // State, counter, capture and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage write port; reset forces IDLE so no write can fire while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= cap_q.wdata;
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        mem_we_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.req) begin
                    cap_d.wen   = bus_if.wen;
                    cap_d.addr  = bus_if.addr;
                    cap_d.wdata = bus_if.wdata;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    busy_d      = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    if (hit_c) begin
                        if (cap_q.wen) begin
                            mem_we_c = 1'b1;
                            rdata_d  = cap_q.wdata;
                        end else begin
                            rdata_d  = mem[idx_c];
                        end
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                // req is deliberately ignored here, giving one bubble between requests.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_if.ready = ready_q;
    assign bus_if.rdata = rdata_q;
    assign bus_if.err   = err_q;
    assign bus_if.busy  = busy_q;

endmodule

// File: tb/tb_latency_mem_responder.sv
// Self-checking bench: two responders (latency 4 and latency 1) driven with
// directed and random traffic, compared against a word-array reference model.
module tb_latency_mem_responder;
    import latency_mem_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    latency_mem_responder_if bus4 ();
    latency_mem_responder_if bus1 ();

    latency_mem_responder #(.WORD_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) dut4 (
        .clk (clk), .rst (rst), .bus_if (bus4)
    );
    latency_mem_responder #(.WORD_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rst), .bus_if (bus1)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [2][DEPTH];
    int          lat_of [2] = '{4, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic set_in(input int sel, input logic req, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == 0) begin
            bus4.req = req; bus4.wen = wen; bus4.addr = addr; bus4.wdata = wdata;
        end else begin
            bus1.req = req; bus1.wen = wen; bus1.addr = addr; bus1.wdata = wdata;
        end
    endtask

    task automatic get_out(input int sel, output logic r, output logic [31:0] d,
                           output logic e, output logic b);
        if (sel == 0) begin
            r = bus4.ready; d = bus4.rdata; e = bus4.err; b = bus4.busy;
        end else begin
            r = bus1.ready; d = bus1.rdata; e = bus1.err; b = bus1.busy;
        end
    endtask

    // Reference: a word array indexed from BASE; anything else errors with zero data.
    task automatic ref_access(input int sel, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd, output logic e);
        longint unsigned a;
        int              idx;
        a = {32'h0, addr};
        if (a >= BASE && a < longint'(BASE) + 4 * DEPTH && (a % 4) == 0) begin
            idx = int'((a - BASE) / 4);
            e   = 1'b0;
            if (wen) begin
                ref_mem[sel][idx] = wdata;
                rd = wdata;
            end else begin
                rd = ref_mem[sel][idx];
            end
        end else begin
            rd = 32'h0;
            e  = 1'b1;
        end
    endtask

    function automatic logic [31:0] word_of(input int sel, input int i);
        return (sel == 0) ? dut4.mem[i] : dut1.mem[i];
    endfunction

    task automatic check_array(input int sel, input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, word_of(sel, i), ref_mem[sel][i]);
    endtask

    // One full transaction; optional scrambling of the bus while the access is pending.
    task automatic txn(input int sel, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit scramble, input string tag,
                       output logic [31:0] rd_o, output logic err_o);
        logic [31:0] exp_rd, d;
        logic        exp_e, r, e, b;
        int          lat;
        bit          seen;
        ref_access(sel, wen, addr, wdata, exp_rd, exp_e);
        @(negedge clk);
        set_in(sel, 1'b1, wen, addr, wdata);
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        rd_o = 32'h0;
        err_o = 1'b0;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(posedge clk); #1;
            get_out(sel, r, d, e, b);
            if (r) begin
                seen  = 1'b1;
                lat   = c;
                rd_o  = d;
                err_o = e;
            end else begin
                if (c == 1) check({tag, "_busy"}, 32'(b), 32'd1);
                if (scramble)
                    set_in(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom, $urandom);
            end
        end
        set_in(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_lat"},   32'(lat),   32'(lat_of[sel]));
            check({tag, "_rdata"}, rd_o,       exp_rd);
            check({tag, "_err"},   32'(err_o), 32'(exp_e));
            @(posedge clk); #1;
            get_out(sel, r, d, e, b);
            check({tag, "_pulse"}, 32'({r, e, b}), 32'd0);
            check({tag, "_hold"},  d, exp_rd);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            1:       return BASE + 32'(4 * (DEPTH + $urandom_range(0, 3)));
            2:       return BASE - 32'(4 * $urandom_range(1, 4));
            3:       return $urandom;
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        logic [31:0] rd, d, d1, d2, old, a;
        logic        er, r, e, b, e1, e2;
        int          p1, p2, sel;

        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        get_out(0, r, d, e, b);
        check("reset_outputs", {28'h0, r, e, b, 1'b0}, 32'h0);
        check("reset_rdata", d, 32'h0);

        // Fill both stores through the bus so the model knows every word.
        for (int i = 0; i < DEPTH; i++)
            for (int s = 0; s < 2; s++)
                txn(s, 1'b1, BASE + 32'(4 * i), $urandom, 1'b0, "preload", rd, er);
        check_array(0, "preload_mem4");
        check_array(1, "preload_mem1");

        // Write then read back DEADBEEF at word 2.
        txn(0, 1'b1, 32'h0001_0008, 32'hDEAD_BEEF, 1'b0, "wr_beef", rd, er);
        txn(0, 1'b0, 32'h0001_0008, 32'h0, 1'b0, "rd_beef", rd, er);
        check("rd_beef_const", rd, 32'hDEAD_BEEF);
        check("rd_beef_err", 32'(er), 32'd0);
        check("mem2_beef", dut4.mem[2], 32'hDEAD_BEEF);

        // Boundary and illegal addresses.
        txn(0, 1'b0, 32'h0001_0090, 32'h0, 1'b0, "rd_end", rd, er);
        check("rd_end_err", 32'(er), 32'd1);
        txn(0, 1'b1, 32'h0001_0090, 32'hFFFF_FFFF, 1'b0, "wr_end", rd, er);
        check_array(0, "end_mem");
        txn(0, 1'b0, 32'h0001_0006, 32'h0, 1'b0, "rd_misal", rd, er);
        check("rd_misal_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0000_FFFC, 32'h0, 1'b0, "rd_below", rd, er);
        check("rd_below_err", 32'(er), 32'd1);
        check("rd_below_rdata", rd, 32'h0);

        // Reset two cycles into WAIT with req high: write must be dropped.
        old = ref_mem[0][4];
        @(negedge clk);
        set_in(0, 1'b1, 1'b1, BASE + 32'd16, 32'h1234_5678);
        @(posedge clk);
        @(posedge clk); #1;
        set_in(0, 1'b1, 1'b0, $urandom, $urandom);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        get_out(0, r, d, e, b);
        check("midrst_flags", {29'h0, r, e, b}, 32'h0);
        check("midrst_rdata", d, 32'h0);
        @(posedge clk);
        check("midrst_mem", dut4.mem[4], old);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        get_out(0, r, d, e, b);
        check("postrst_idle", {29'h0, r, e, b}, 32'h0);
        check("postrst_mem", dut4.mem[4], old);
        txn(0, 1'b1, BASE + 32'd16, 32'h1234_5678, 1'b1, "reissue", rd, er);
        check("reissue_mem", dut4.mem[4], 32'h1234_5678);

        // Back-to-back reads on the latency-1 responder with req held high.
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, BASE, 32'h0);
        p1 = -1; p2 = -1; d1 = 0; d2 = 0; e1 = 1'b1; e2 = 1'b1;
        for (int c = 0; c < 40 && p2 < 0; c++) begin
            @(posedge clk); #1;
            get_out(1, r, d, e, b);
            if (r) begin
                if (p1 < 0) begin
                    p1 = c; d1 = d; e1 = e;
                    set_in(1, 1'b1, 1'b0, BASE + 32'd140, 32'h0);
                end else begin
                    p2 = c; d2 = d; e2 = e;
                    set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
        end
        set_in(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("b2b_seen", 32'(p2 >= 0), 32'd1);
        check("b2b_gap", 32'(p2 - p1), 32'(lat_of[1] + 2));
        check("b2b_rd0", d1, ref_mem[1][0]);
        check("b2b_rd35", d2, ref_mem[1][35]);
        check("b2b_err", {30'h0, e1, e2}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        get_out(1, r, d, e, b);
        check("b2b_quiet", {29'h0, r, e, b}, 32'h0);

        // Random traffic with bus scrambling while requests are pending.
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 1));
            a   = rand_addr();
            txn(sel, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, "rand", rd, er);
        end
        check_array(0, "final_mem4");
        check_array(1, "final_mem1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
